vga_frame_reader: RTL and testbench



---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_timing_gen.sv | 53 +++++
 rtl/vga_frame_reader.sv | 138 +++++++++++++
 tb/tb_vga_frame_reader.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing, reader state encoding and RGB444 layout
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CH_W  = 4;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters with raw sync, visible and frame-start flags
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS        = vga_pkg::H_VIS,
  parameter int H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = vga_pkg::H_SYNC_END,
  parameter int H_TOTAL      = vga_pkg::H_TOTAL,
  parameter int V_VIS        = vga_pkg::V_VIS,
  parameter int V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = vga_pkg::V_SYNC_END,
  parameter int V_TOTAL      = vga_pkg::V_TOTAL
) (
  input  logic             clk_p,
  input  logic             rst_n,
  input  logic             pix_ce,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             visible,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_SS = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] H_SE = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] V_SS = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] V_SE = CNT_W'(V_SYNC_END);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign hs_raw      = (h_cnt >= H_SS) && (h_cnt <= H_SE);
  assign vs_raw      = (v_cnt >= V_SS) && (v_cnt <= V_SE);
  assign visible     = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign frame_start = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - scans the frame buffer in raster order and drives a VGA monitor
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19,
  parameter int IMG_W      = 400,
  parameter int IMG_H      = 300,
  parameter int X_OFF      = 120,
  parameter int Y_OFF      = 90,
  parameter int H_VIS      = vga_pkg::H_VIS,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_VIS      = vga_pkg::V_VIS,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  pix_ce,
  input  logic                  frame_ready,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] X_LO = CNT_W'(X_OFF);
  localparam logic [CNT_W-1:0] X_HI = CNT_W'(X_OFF + IMG_W);
  localparam logic [CNT_W-1:0] Y_LO = CNT_W'(Y_OFF);
  localparam logic [CNT_W-1:0] Y_HI = CNT_W'(Y_OFF + IMG_H);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_W * IMG_H - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic hs_raw, vs_raw, visible, frame_start;

  vga_timing_gen #(
    .H_VIS       (H_VIS),
    .H_SYNC_START(H_VIS + H_FP),
    .H_SYNC_END  (H_VIS + H_FP + H_SYNC - 1),
    .H_TOTAL     (H_VIS + H_FP + H_SYNC + H_BP),
    .V_VIS       (V_VIS),
    .V_SYNC_START(V_VIS + V_FP),
    .V_SYNC_END  (V_VIS + V_FP + V_SYNC - 1),
    .V_TOTAL     (V_VIS + V_FP + V_SYNC + V_BP)
  ) u_timing (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .visible    (visible),
    .frame_start(frame_start)
  );

  logic in_img, img_first, show;
  assign in_img    = visible && (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                     (v_cnt >= Y_LO) && (v_cnt < Y_HI);
  assign img_first = in_img && (h_cnt == X_LO) && (v_cnt == Y_LO);

  state_t state, state_nx;
  assign show = (state == ST_SHOW);

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT:  if (frame_ready) state_nx = ST_ARMED;
      ST_ARMED: begin
        if (!frame_ready)              state_nx = ST_WAIT;
        else if (pix_ce && frame_start) state_nx = ST_SHOW;
      end
      ST_SHOW:  if (!frame_ready) state_nx = ST_WAIT;
      default:  state_nx = ST_WAIT;
    endcase
  end

  // Stage 1: address of the pixel whose flags are registered alongside it.
  logic img1, hs1, vs1;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      img1   <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      r_addr <= '0;
    end else if (pix_ce) begin
      img1 <= in_img && show;
      hs1  <= hs_raw;
      vs1  <= vs_raw;
      if (frame_start || !show || img_first) begin
        r_addr <= '0;
      end else if (in_img && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // Stage 2: memory data has settled by the next pix_ce, capture it with sync.
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_ce && show && img1 && (r_addr == LAST_ADDR);
      if (pix_ce) begin
        vga_hs <= ~hs1;
        vga_vs <= ~vs1;
        if (show && img1) begin
          vga_r <= r_data[R_LSB +: CH_W];
          vga_g <= r_data[G_LSB +: CH_W];
          vga_b <= r_data[B_LSB +: CH_W];
        end else begin
          vga_r <= '0;
          vga_g <= '0;
          vga_b <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - randomized-spacing bench for vga_frame_reader with a raster reference model
module tb_vga_frame_reader;

  localparam int HV = 40, HF = 4, HS = 6, HB = 6;
  localparam int VV = 30, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int IW = 20, IH = 12, XO = 8, YO = 6;

  logic        clk_p = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic        frame_ready;
  logic [18:0] r_addr;
  logic [11:0] r_data;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_done;
  logic [11:0] mask;

  int checks = 0;
  int errors = 0;

  int tk, ph, pv;
  bit st_show, armed, pvalid, psh;

  vga_frame_reader #(
    .DATA_WIDTH(12), .ADDR_WIDTH(19),
    .IMG_W(IW), .IMG_H(IH), .X_OFF(XO), .Y_OFF(YO),
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .pix_ce     (pix_ce),
    .frame_ready(frame_ready),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_done (frame_done)
  );

  always #5 clk_p = ~clk_p;

  // Frame buffer: contents derived from the address, one clk_p read latency.
  always @(posedge clk_p) r_data <= r_addr[11:0] ^ mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic bit in_img(int h, int v);
    return (h >= XO) && (h < XO + IW) && (v >= YO) && (v < YO + IH);
  endfunction

  function automatic int pix_index(int h, int v);
    return (v - YO) * IW + (h - XO);
  endfunction

  // Address of the latest image pixel reached in raster order this frame.
  function automatic int addr_at(int h, int v);
    int cols;
    int p;
    if (v < YO) p = 0;
    else if (v >= YO + IH) p = IW * IH;
    else begin
      cols = h - XO + 1;
      if (cols < 0) cols = 0;
      if (cols > IW) cols = IW;
      p = (v - YO) * IW + cols;
    end
    return (p == 0) ? 0 : p - 1;
  endfunction

  task automatic do_tick();
    int h, v, ea;
    bit sh_now, last_px, fstart;
    logic [11:0] ecol;
    @(posedge clk_p); #1;
    check("frame_done_width", 32'(frame_done), 32'd0);
    if ($urandom_range(0, 1) == 1) begin
      @(posedge clk_p); #1;
    end
    pix_ce = 1'b1;
    @(posedge clk_p); #1;
    pix_ce = 1'b0;

    h      = tk % HT;
    v      = (tk / HT) % VT;
    fstart = (h == HT - 1) && (v == VT - 1);
    sh_now = st_show;

    if (pvalid && psh && sh_now && in_img(ph, pv)) ecol = 12'(pix_index(ph, pv)) ^ mask;
    else ecol = 12'd0;
    check("colour", 32'({vga_r, vga_g, vga_b}), 32'(ecol));
    check("hsync", 32'(vga_hs), 32'(!(pvalid && ph >= HV + HF && ph < HV + HF + HS)));
    check("vsync", 32'(vga_vs), 32'(!(pvalid && pv >= VV + VF && pv < VV + VF + VS)));
    last_px = (ph == XO + IW - 1) && (pv == YO + IH - 1);
    check("frame_done", 32'(frame_done), 32'(pvalid && psh && sh_now && last_px));
    ea = (sh_now && !fstart) ? addr_at(h, v) : 0;
    check("r_addr", 32'(r_addr), 32'(ea));
    if (pvalid && psh && sh_now && ph == XO + 5 && pv == YO + 2 && mask == 12'd0)
      check("pixel_x5_y2", 32'({vga_r, vga_g, vga_b}), 32'(2 * IW + 5));

    if (armed && fstart) st_show = 1'b1;
    ph = h;
    pv = v;
    psh = sh_now;
    pvalid = 1'b1;
    tk++;
  endtask

  task automatic run_to(int target);
    while (tk < target) do_tick();
  endtask

  initial begin
    rst_n = 1'b0;
    pix_ce = 1'b0;
    frame_ready = 1'b0;
    mask = 12'd0;
    tk = 0; ph = 0; pv = 0;
    st_show = 1'b0; armed = 1'b0; pvalid = 1'b0; psh = 1'b0;

    repeat (3) @(posedge clk_p);
    #1;
    check("reset_r_addr", 32'(r_addr), 32'd0);
    check("reset_colour", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("reset_hs", 32'(vga_hs), 32'd1);
    check("reset_vs", 32'(vga_vs), 32'd1);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    #2 rst_n = 1'b1;

    // Idle frame, then raise ready partway into the next frame.
    run_to(FT + 20 * HT);
    frame_ready = 1'b1;
    armed = 1'b1;
    run_to(3 * FT);

    mask = 12'($urandom);
    run_to(3 * FT + 10 * HT + 20);
    frame_ready = 1'b0;
    armed = 1'b0;
    st_show = 1'b0;
    run_to(3 * FT + 14 * HT);
    frame_ready = 1'b1;
    armed = 1'b1;
    run_to(4 * FT);
    mask = 12'($urandom);
    run_to(5 * FT + 8 * HT + 15);

    // Asynchronous reset in the middle of an image line.
    @(posedge clk_p);
    #3 rst_n = 1'b0;
    #1;
    check("async_r_addr", 32'(r_addr), 32'd0);
    check("async_colour", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("async_hs", 32'(vga_hs), 32'd1);
    check("async_vs", 32'(vga_vs), 32'd1);
    check("async_frame_done", 32'(frame_done), 32'd0);
    #2 rst_n = 1'b1;
    tk = 0;
    pvalid = 1'b0;
    psh = 1'b0;
    st_show = 1'b0;
    armed = 1'b1;
    run_to(FT + 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
